// File: rtl/regfile_scoreboard_pkg.sv
// rtl/regfile_scoreboard_pkg.sv - shared defaults and types for the register file
package regfile_scoreboard_pkg;

    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;
    localparam int REG_ZERO = 0;

    typedef logic [AW_DEF-1:0] regaddr_t;
    typedef logic [DW_DEF-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - read, write, issue and debug signals of the register file
interface regfile_scoreboard_if #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int NR = 2
);

    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rbusy;
    logic             we0;
    logic [AW-1:0]    wa0;
    logic [DW-1:0]    wd0;
    logic             we1;
    logic [AW-1:0]    wa1;
    logic [DW-1:0]    wd1;
    logic             set_en;
    logic [AW-1:0]    set_a;
    logic [AW-1:0]    raout;
    logic [DW-1:0]    rdout;
    logic [AW:0]      busy_cnt;

    modport master (
        output ra, we0, wa0, wd0, we1, wa1, wd1, set_en, set_a, raout,
        input  rd, rbusy, rdout, busy_cnt
    );

    modport slave (
        input  ra, we0, wa0, wd0, we1, wa1, wd1, set_en, set_a, raout,
        output rd, rbusy, rdout, busy_cnt
    );

endinterface

// File: rtl/regfile_scoreboard_fwd_mux.sv
// rtl/regfile_scoreboard_fwd_mux.sv - write-forwarding read mux for one read port
module regfile_scoreboard_fwd_mux
    import regfile_scoreboard_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] stored,
    input  logic          we0,
    input  logic [AW-1:0] wa0,
    input  logic [DW-1:0] wd0,
    input  logic          we1,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd1,
    output logic [DW-1:0] data,
    output logic          hit
);

    logic is_zero;
    logic hit0;
    logic hit1;

    assign is_zero = ZERO_REG && (addr == AW'(REG_ZERO));
    assign hit1    = we1 && (addr == wa1) && !is_zero;
    assign hit0    = we0 && (addr == wa0) && !is_zero;

    // hit means the stored state is bypassed, so a stale busy bit must not show
    assign hit = hit0 || hit1 || is_zero;

    // port 1 has priority, matching the write ordering in the array
    always_comb begin
        data = stored;
        if (is_zero) begin
            data = '0;
        end else if (hit1) begin
            data = wd1;
        end else if (hit0) begin
            data = wd0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - dual-write register file with busy scoreboard and forwarding
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int NR       = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    regfile_scoreboard_if.slave bus
);

    localparam int DEPTH = 2**AW;

    logic [DW-1:0]    rf [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic [AW:0]      busy_cnt_q;
    logic [AW:0]      cnt_next;
    logic             wr0_ok;
    logic             wr1_ok;

    // port index NR is the debug port
    logic [NR:0][AW-1:0] port_addr;
    logic [NR:0][DW-1:0] port_data;
    logic [NR:0]         port_hit;
    logic                unused_dbg_hit;

    assign wr0_ok = bus.we0 && !(ZERO_REG && (bus.wa0 == AW'(REG_ZERO)));
    assign wr1_ok = bus.we1 && !(ZERO_REG && (bus.wa1 == AW'(REG_ZERO)));

    // writebacks retire their destination, then a new issue re-marks it busy
    always_comb begin
        busy_next = busy;
        if (bus.we0) begin
            busy_next[bus.wa0] = 1'b0;
        end
        if (bus.we1) begin
            busy_next[bus.wa1] = 1'b0;
        end
        if (bus.set_en) begin
            busy_next[bus.set_a] = 1'b1;
        end
        if (ZERO_REG) begin
            busy_next[REG_ZERO] = 1'b0;
        end
    end

    // recomputed population count of the post-update busy vector
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + {{AW{1'b0}}, busy_next[i]};
        end
    end

    // register array, busy bits and count; port 1 written last so it wins
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
            busy       <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (wr0_ok) begin
                rf[bus.wa0] <= bus.wd0;
            end
            if (wr1_ok) begin
                rf[bus.wa1] <= bus.wd1;
            end
            busy       <= busy_next;
            busy_cnt_q <= cnt_next;
        end
    end

    for (genvar i = 0; i <= NR; i++) begin : g_port
        if (i < NR) begin : g_operand
            assign port_addr[i] = bus.ra[i*AW +: AW];
        end else begin : g_debug
            assign port_addr[i] = bus.raout;
        end

        regfile_scoreboard_fwd_mux #(
            .AW       (AW),
            .DW       (DW),
            .ZERO_REG (ZERO_REG)
        ) u_mux (
            .addr   (port_addr[i]),
            .stored (rf[port_addr[i]]),
            .we0    (bus.we0),
            .wa0    (bus.wa0),
            .wd0    (bus.wd0),
            .we1    (bus.we1),
            .wa1    (bus.wa1),
            .wd1    (bus.wd1),
            .data   (port_data[i]),
            .hit    (port_hit[i])
        );
    end

    // pack operand ports; a forwarded operand is never reported busy
    always_comb begin
        bus.rd    = '0;
        bus.rbusy = '0;
        for (int i = 0; i < NR; i++) begin
            bus.rd[i*DW +: DW] = port_data[i];
            bus.rbusy[i]       = busy[port_addr[i]] && !port_hit[i];
        end
    end

    assign bus.rdout    = port_data[NR];
    assign bus.busy_cnt = busy_cnt_q;
    assign unused_dbg_hit = port_hit[NR];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;
    import regfile_scoreboard_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.AW(AW), .DW(DW), .NR(NR)) bus ();

    regfile_scoreboard #(
        .AW       (AW),
        .DW       (DW),
        .NR       (NR),
        .ZERO_REG (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_rf   [DEPTH];
    bit            m_busy [DEPTH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (bus.we1 && a == bus.wa1) return bus.wd1;
        if (bus.we0 && a == bus.wa0) return bus.wd0;
        return m_rf[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (bus.we1 && a == bus.wa1) return 1'b0;
        if (bus.we0 && a == bus.wa0) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic check_outputs(input string tag);
        for (int p = 0; p < NR; p++) begin
            check({tag, "_rd"}, 64'(bus.rd[p*DW +: DW]), 64'(exp_read(bus.ra[p*AW +: AW])));
            check({tag, "_rbusy"}, 64'(bus.rbusy[p]), 64'(exp_busy(bus.ra[p*AW +: AW])));
        end
        check({tag, "_rdout"}, 64'(bus.rdout), 64'(exp_read(bus.raout)));
        check({tag, "_cnt"}, 64'(bus.busy_cnt), 64'(m_count()));
    endtask

    task automatic idle();
        rst        = 1'b0;
        bus.we0    = 1'b0;
        bus.wa0    = '0;
        bus.wd0    = '0;
        bus.we1    = 1'b0;
        bus.wa1    = '0;
        bus.wd1    = '0;
        bus.set_en = 1'b0;
        bus.set_a  = '0;
    endtask

    // advance one edge and apply the architectural update rules to the model
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_rf[i]   = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (bus.we0 && bus.wa0 != 0) m_rf[bus.wa0] = bus.wd0;
            if (bus.we1 && bus.wa1 != 0) m_rf[bus.wa1] = bus.wd1;
            if (bus.we0) m_busy[bus.wa0] = 1'b0;
            if (bus.we1) m_busy[bus.wa1] = 1'b0;
            if (bus.set_en && bus.set_a != 0) m_busy[bus.set_a] = 1'b1;
        end
        #1;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic randomize_inputs(input int rst_pct);
        rst        = ($urandom_range(0, 99) < rst_pct);
        bus.we0    = 1'($urandom_range(0, 1));
        bus.wa0    = rnd_addr();
        bus.wd0    = $urandom;
        bus.we1    = 1'($urandom_range(0, 1));
        bus.wa1    = rnd_addr();
        bus.wd1    = $urandom;
        bus.set_en = 1'($urandom_range(0, 1));
        bus.set_a  = rnd_addr();
        bus.ra     = {rnd_addr(), rnd_addr()};
        bus.raout  = rnd_addr();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit");
    end

    initial begin
        idle();
        bus.ra    = '0;
        bus.raout = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #2;
        check_outputs("reset_init");

        // reset after random activity clears everything
        for (int n = 0; n < 20; n++) begin
            randomize_inputs(0);
            tick();
        end
        randomize_inputs(0);
        rst = 1'b1;
        tick();
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            bus.raout = AW'(a);
            bus.ra    = {AW'(a), AW'(DEPTH - 1 - a)};
            #1;
            check("rst_rdout", 64'(bus.rdout), 64'd0);
            check("rst_rd0", 64'(bus.rd[DW-1:0]), 64'd0);
            check("rst_rd1", 64'(bus.rd[2*DW-1:DW]), 64'd0);
            check("rst_rbusy", 64'(bus.rbusy), 64'd0);
        end
        check("rst_cnt", 64'(bus.busy_cnt), 64'd0);

        // same-cycle forwarding, then the stored value
        bus.we0 = 1'b1; bus.wa0 = 5; bus.wd0 = 32'hDEADBEEF;
        bus.ra  = {AW'(0), AW'(5)};
        #2;
        check("fwd_same", 64'(bus.rd[DW-1:0]), 64'hDEADBEEF);
        tick();
        idle();
        #2;
        check("fwd_next", 64'(bus.rd[DW-1:0]), 64'hDEADBEEF);

        // write collision: port 1 wins
        bus.we0 = 1'b1; bus.wa0 = 7; bus.wd0 = 32'h11;
        bus.we1 = 1'b1; bus.wa1 = 7; bus.wd1 = 32'h22;
        bus.ra  = {AW'(7), AW'(0)};
        #2;
        check("coll_fwd", 64'(bus.rd[2*DW-1:DW]), 64'h22);
        tick();
        idle();
        bus.ra = {AW'(0), AW'(7)};
        #2;
        check("coll_stored", 64'(bus.rd[DW-1:0]), 64'h22);

        // register 0 ignores writes
        bus.we0 = 1'b1; bus.wa0 = 0; bus.wd0 = 32'hFFFF;
        bus.we1 = 1'b1; bus.wa1 = 0; bus.wd1 = 32'hFFFF;
        bus.ra  = '0; bus.raout = 0;
        #2;
        check("zero_fwd", 64'(bus.rd[DW-1:0]), 64'd0);
        check("zero_fwd_dbg", 64'(bus.rdout), 64'd0);
        tick();
        idle();
        #2;
        check("zero_stored", 64'(bus.rd[DW-1:0]), 64'd0);

        // scoreboard set, forwarded clear, retire
        bus.set_en = 1'b1; bus.set_a = 3;
        bus.ra = {AW'(0), AW'(3)};
        #2;
        check("sb_set_invisible", 64'(bus.rbusy[0]), 64'd0);
        tick();
        idle();
        #2;
        check("sb_busy", 64'(bus.rbusy[0]), 64'd1);
        check("sb_cnt1", 64'(bus.busy_cnt), 64'd1);
        bus.we1 = 1'b1; bus.wa1 = 3; bus.wd1 = 32'h3333;
        #2;
        check("sb_fwd_clear", 64'(bus.rbusy[0]), 64'd0);
        tick();
        idle();
        #2;
        check("sb_retired", 64'(bus.rbusy[0]), 64'd0);
        check("sb_cnt0", 64'(bus.busy_cnt), 64'd0);

        // set wins over a same-cycle clear
        bus.set_en = 1'b1; bus.set_a = 9;
        tick();
        idle();
        bus.we0 = 1'b1; bus.wa0 = 9; bus.wd0 = 32'h99;
        bus.set_en = 1'b1; bus.set_a = 9;
        tick();
        idle();
        bus.ra = {AW'(0), AW'(9)};
        #2;
        check("race_busy", 64'(bus.rbusy[0]), 64'd1);
        check("race_cnt", 64'(bus.busy_cnt), 64'd1);
        check_outputs("race_model");

        // reset in the middle of activity
        for (int r = 1; r <= 4; r++) begin
            bus.set_en = 1'b1; bus.set_a = AW'(r);
            tick();
        end
        idle();
        #2;
        check("mid_cnt4", 64'(bus.busy_cnt), 64'd5);
        rst = 1'b1;
        bus.we0 = 1'b1; bus.wa0 = 2; bus.wd0 = 32'h55;
        bus.set_en = 1'b1; bus.set_a = 6;
        tick();
        idle();
        bus.ra = {AW'(6), AW'(2)};
        #2;
        check("mid_reg2", 64'(bus.rd[DW-1:0]), 64'd0);
        check("mid_cnt", 64'(bus.busy_cnt), 64'd0);
        check("mid_rbusy", 64'(bus.rbusy), 64'd0);

        // randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            randomize_inputs(2);
            #2;
            if (!rst) check_outputs("rand");
            tick();
        end
        idle();
        #2;
        check_outputs("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
